// File: rtl/ted_scrub_memory.sv
// ted_scrub_memory: Avalon-MM on-chip RAM with pipelined reads and a hardware scrub engine
// that overwrites every word with SCRUB_VALUE after reset or on request.
module ted_scrub_memory #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DEPTH          = 65000,
  parameter int                    READ_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] SCRUB_VALUE    = '0,
  parameter bit                    SCRUB_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    scrub_req,
  output logic                    scrub_busy,
  output logic                    scrub_done,
  output logic                    range_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, SCRUB, DONE} state_e;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    v1_q, v2_q, range_err_q;
  logic [DATA_WIDTH-1:0]   d1_q, d2_q;
  logic                    en, start, oor, acc, wr_acc, rd_acc;
  assign en     = clken & ~reset_req;
  assign start  = en & scrub_req & (state_q == IDLE);
  assign oor    = 32'(address) >= 32'(DEPTH);
  assign acc    = chipselect & (read | write) & ~waitrequest;
  assign wr_acc = acc & write & ~oor;
  assign rd_acc = acc & read & ~write;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCRUB_ON_RESET ? SCRUB : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (en) begin
      state_d = state_q == IDLE  ? (scrub_req ? SCRUB : IDLE) :
                state_q == SCRUB ? (ptr_q == LAST ? DONE : SCRUB) : IDLE;
      ptr_d   = state_q == SCRUB ? ptr_q + 1'b1 : '0;
    end
  end
  // Start-of-scrub cycle also raises waitrequest so no access races the pointer clear.
  always_comb begin
    scrub_busy  = state_q != IDLE;
    scrub_done  = (state_q == DONE) & en;
    waitrequest = ~reset_n | ~en | (state_q != IDLE) | start;
  end
  always_ff @(posedge clk) begin
    if (en && state_q == SCRUB)
      mem[ptr_q[IW-1:0]] <= SCRUB_VALUE;
    else if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) mem[address[IW-1:0]][i*8 +: 8] <= writedata[i*8 +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      range_err_q <= 1'b0;
    end else if (en) begin
      v1_q        <= rd_acc;
      v2_q        <= v1_q;
      d1_q        <= rd_acc ? (oor ? '0 : mem[address[IW-1:0]]) : d1_q;
      d2_q        <= d1_q;
      range_err_q <= start ? 1'b0 : range_err_q | (acc & oor);
    end
  end
  assign readdata      = READ_LATENCY == 2 ? d2_q : d1_q;
  assign readdatavalid = en & (READ_LATENCY == 2 ? v2_q : v1_q);
  assign range_err     = range_err_q;
endmodule

// File: tb/tb_ted_scrub_memory.sv
// tb_ted_scrub_memory: scoreboard bench driving a latency-1 and a latency-2 instance
// (DEPTH reduced to 1000 so full scrubs stay short) with shared directed stimulus.
module tb_ted_scrub_memory;
  localparam int D = 1000;
  localparam logic [31:0] SV1 = 32'hA5A5_A5A5;
  typedef struct {logic [31:0] d; int t;} exp_t;
  logic clk = 0, reset_n = 0, chipselect = 0, read = 0, write = 0;
  logic clken = 1, reset_req = 0, scrub_req = 0;
  logic [15:0] address = '0;
  logic [3:0] byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rdata0, rdata1;
  logic rv0, rv1, wr0, wr1, busy0, busy1, done0, done1, rerr0, rerr1;
  int checks = 0, errors = 0, ecnt = 0, dcnt = 0;
  exp_t q0[$], q1[$];
  ted_scrub_memory #(.DEPTH(D), .READ_LATENCY(1)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .readdata(rdata0), .readdatavalid(rv0), .waitrequest(wr0), .clken(clken),
    .reset_req(reset_req), .scrub_req(scrub_req), .scrub_busy(busy0),
    .scrub_done(done0), .range_err(rerr0));
  ted_scrub_memory #(.DEPTH(D), .READ_LATENCY(2), .SCRUB_VALUE(SV1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .readdata(rdata1), .readdatavalid(rv1), .waitrequest(wr1), .clken(clken),
    .reset_req(reset_req), .scrub_req(scrub_req), .scrub_busy(busy1),
    .scrub_done(done1), .range_err(rerr1));
  always #5 clk = ~clk;
  always @(posedge clk) if (reset_n && clken && !reset_req) ecnt <= ecnt + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Monitor: every readdatavalid pops the matching expectation (data and enabled-cycle tag).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0) dcnt++;
      if (rv0) begin
        if (q0.size() == 0) chk("rv0_unexpected", 32'(rv0), 0);
        else begin
          e = q0.pop_front();
          chk("rd0_data", rdata0, e.d);
          chk("rd0_cycle", ecnt, e.t);
          chk("rd0_en", 32'(clken & ~reset_req), 1);
        end
      end
      if (rv1) begin
        if (q1.size() == 0) chk("rv1_unexpected", 32'(rv1), 0);
        else begin
          e = q1.pop_front();
          chk("rd1_data", rdata1, e.d);
          chk("rd1_cycle", ecnt, e.t);
          chk("rd1_en", 32'(clken & ~reset_req), 1);
        end
      end
    end
  end
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1; write = 1; read = 0; address = a; writedata = d; byteenable = be;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] e0, input logic [31:0] e1);
    chipselect = 1; read = 1; write = 0; address = a;
    q0.push_back('{e0, ecnt + 1});
    q1.push_back('{e1, ecnt + 2});
    @(posedge clk); #1;
    chipselect = 0; read = 0;
  endtask
  task automatic wait_scrub(input string n, input int len, input int ndone);
    int c = 0;
    bit seen = 0;
    while (c < D + 100 && !seen) begin
      @(posedge clk); c++;
      @(negedge clk); seen = done0;
    end
    chk({n, "_len"}, c, len);
    chk({n, "_done1"}, 32'(done1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({n, "_count"}, dcnt, ndone);
    chk({n, "_wait_low"}, 32'({wr0, wr1, busy0, busy1, done0}), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    chk("rst_rdata", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_flags", 32'({rv0, rv1, done0, done1, rerr0, rerr1}), 0);
    chk("rst_busy", 32'({busy0, busy1}), 2'b11);
    chk("rst_wait", 32'({wr0, wr1}), 2'b11);
    @(posedge clk); #1 reset_n = 1;
    wait_scrub("reset_scrub", D, 1);
    rd(16'd0, 0, SV1);
    rd(16'd500, 0, SV1);
    rd(16'd999, 0, SV1);
    wr(16'h0010, 32'hAABBCCDD, 4'hF);
    wr(16'h0010, 32'h11223344, 4'h5);
    rd(16'h0010, 32'hAA22CC44, 32'hAA22CC44);
    for (int i = 1; i <= 3; i++) wr(16'(32 + i - 1), 32'(i), 4'hF);
    for (int i = 1; i <= 3; i++) rd(16'(32 + i - 1), 32'(i), 32'(i));
    chipselect = 1; read = 1; write = 1; address = 16'h0030; writedata = 32'h77; byteenable = 4'hF;
    @(posedge clk); #1;
    chipselect = 0; read = 0; write = 0;
    rd(16'h0030, 32'h77, 32'h77);
    rd(16'h0021, 32'd2, 32'd2);
    clken = 0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_wait", 32'({wr0, wr1}), 2'b11);
      chk("stall_rv", 32'({rv0, rv1}), 0);
      @(posedge clk);
    end
    #1 clken = 1; reset_req = 1;
    @(negedge clk);
    chk("hold_wait", 32'(wr0), 1);
    @(posedge clk); #1 reset_req = 0;
    repeat (3) @(posedge clk); #1;
    wr(16'd1000, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("oor_err", 32'({rerr0, rerr1}), 2'b11);
    @(posedge clk); #1;
    wr(16'd1024, 32'hDEADBEEF, 4'hF);
    rd(16'd1000, 0, 0);
    rd(16'd0, 0, SV1);
    wr(16'h0040, 32'h1234, 4'hF);
    wr(16'd900, 32'h55, 4'hF);
    rd(16'h0040, 32'h1234, 32'h1234);
    scrub_req = 1;
    @(posedge clk); #1 scrub_req = 0;
    chk("scrub_err_clr", 32'({rerr0, rerr1}), 0);
    chk("scrub_busy", 32'({busy0, wr0}), 2'b11);
    repeat (499) @(posedge clk);
    #1 scrub_req = 1;
    @(posedge clk); #1 scrub_req = 0;
    wait_scrub("req_scrub", D - 500, 2);
    rd(16'h0010, 0, SV1);
    rd(16'd900, 0, SV1);
    wr(16'd900, 32'h66, 4'hF);
    rd(16'd900, 32'h66, 32'h66);
    repeat (3) @(posedge clk); #1;
    scrub_req = 1;
    @(posedge clk); #1 scrub_req = 0;
    repeat (300) @(posedge clk);
    #1 reset_n = 0;
    #1 chk("midrst_state", 32'({busy0, wr0, rerr0, rv0}), 4'b1100);
    @(posedge clk); #1 reset_n = 1;
    wait_scrub("midrst_scrub", D, 3);
    rd(16'd900, 0, SV1);
    rd(16'h0020, 0, SV1);
    repeat (5) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
